hazard_stall_ctrl: RTL

Pipeline stall/flush scheduler for the 5-stage MIPS core. It arbitrates three hazard sources: taken-branch squash, load-use stall, and structural/data hazards on the iterative multiply/divide unit. It drives the PC, IF/ID and ID/EX pipeline-register controls, and sequences the multi-cycle HI/LO unit with a start pulse and a busy countdown. It sits beside the ID stage; its outputs go to the PC register, the IF/ID and ID/EX registers, and the mul/div unit.

---
 rtl/hazard_stall_ctrl_if.sv | 36 +++
 rtl/hazard_stall_ctrl.sv | 102 ++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// Hazard/control bundle between the ID-stage pipeline logic and the stall scheduler.
// The master is the pipeline side; the slave is the scheduler.
interface hazard_stall_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             EXE_MemRead;
    logic [4:0]       EXE_WriteReg;
    logic [4:0]       IFID_Rs;
    logic [4:0]       IFID_Rt;
    logic [1:0]       ID_MulDivOp;
    logic             ID_ReadsHiLo;
    logic             EX_BranchTaken;
    logic             PC_Write;
    logic             IFID_Write;
    logic             IFID_Flush;
    logic             IDEX_Bubble;
    logic             MD_Start;
    logic             MD_IsDiv;
    logic             MD_Busy;
    logic             MD_Done;
    logic [CNT_W-1:0] StallCycles;

    modport master (
        output EXE_MemRead, EXE_WriteReg, IFID_Rs, IFID_Rt,
               ID_MulDivOp, ID_ReadsHiLo, EX_BranchTaken,
        input  PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble,
               MD_Start, MD_IsDiv, MD_Busy, MD_Done, StallCycles
    );

    modport slave (
        input  EXE_MemRead, EXE_WriteReg, IFID_Rs, IFID_Rt,
               ID_MulDivOp, ID_ReadsHiLo, EX_BranchTaken,
        output PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble,
               MD_Start, MD_IsDiv, MD_Busy, MD_Done, StallCycles
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush scheduler for the 5-stage core: branch squash, load-use stall,
// and HI/LO unit sequencing with a busy countdown and a saturating stall counter.
module hazard_stall_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 16
) (
    input  logic               Clk,
    input  logic               Rst_n,
    hazard_stall_ctrl_if.slave bus
);
    localparam int MAX_CYC = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
    localparam int MD_W    = $clog2(MAX_CYC + 1);

    logic [MD_W-1:0]  md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic br_s, lu_s, md_op_s, md_busy_s, mdh_s;
    logic pc_write_s, ifid_write_s, ifid_flush_s, idex_bubble_s;
    logic md_start_s, md_is_div_s, md_done_s;

    // Hazard detection and priority resolution; reset forces the idle pattern.
    always_comb begin
        br_s          = 1'b0;
        lu_s          = 1'b0;
        md_op_s       = 1'b0;
        md_busy_s     = 1'b0;
        mdh_s         = 1'b0;
        pc_write_s    = 1'b1;
        ifid_write_s  = 1'b1;
        ifid_flush_s  = 1'b0;
        idex_bubble_s = 1'b0;
        md_start_s    = 1'b0;
        md_is_div_s   = 1'b0;
        md_done_s     = 1'b0;
        if (!Rst_n) begin
            pc_write_s    = 1'b1;
            ifid_write_s  = 1'b1;
        end else begin
            br_s      = bus.EX_BranchTaken;
            lu_s      = bus.EXE_MemRead && (bus.EXE_WriteReg != 5'd0) &&
                        ((bus.EXE_WriteReg == bus.IFID_Rs) || (bus.EXE_WriteReg == bus.IFID_Rt));
            md_op_s   = (bus.ID_MulDivOp == 2'b01) || (bus.ID_MulDivOp == 2'b10);
            md_busy_s = (md_cnt_q != {MD_W{1'b0}});
            md_done_s = (md_cnt_q == MD_W'(1));
            mdh_s     = md_busy_s && (bus.ID_ReadsHiLo || md_op_s);

            if (br_s) begin
                ifid_flush_s  = 1'b1;
                idex_bubble_s = 1'b1;
            end else if (lu_s || mdh_s) begin
                pc_write_s    = 1'b0;
                ifid_write_s  = 1'b0;
                idex_bubble_s = 1'b1;
            end else begin
                idex_bubble_s = 1'b0;
            end

            md_start_s  = md_op_s && !br_s && !lu_s && !md_busy_s;
            md_is_div_s = md_start_s && (bus.ID_MulDivOp == 2'b10);
        end
    end

    // Next-state for the HI/LO countdown and the saturating stall counter.
    always_comb begin
        md_cnt_d    = md_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (md_start_s) begin
            md_cnt_d = md_is_div_s ? MD_W'(DIV_CYCLES) : MD_W'(MUL_CYCLES);
        end else if (md_cnt_q != {MD_W{1'b0}}) begin
            md_cnt_d = md_cnt_q - MD_W'(1);
        end else begin
            md_cnt_d = md_cnt_q;
        end
        if (!pc_write_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State registers; reset aborts any countdown in flight.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            md_cnt_q    <= {MD_W{1'b0}};
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.PC_Write    = pc_write_s;
    assign bus.IFID_Write  = ifid_write_s;
    assign bus.IFID_Flush  = ifid_flush_s;
    assign bus.IDEX_Bubble = idex_bubble_s;
    assign bus.MD_Start    = md_start_s;
    assign bus.MD_IsDiv    = md_is_div_s;
    assign bus.MD_Busy     = md_busy_s;
    assign bus.MD_Done     = md_done_s;
    assign bus.StallCycles = stall_cnt_q;
endmodule
